// File: rtl/haraka_s_ctrl.sv
// Sequencer for an iterative Haraka-S permutation core: accepts one block, loads it,
// iterates ROUNDS x CORE_LATENCY cycles, captures the result with optional feed-forward.
module haraka_s_ctrl #(
  parameter int ROUNDS       = 5,
  parameter int CORE_LATENCY = 2,
  parameter int FEED_FORWARD = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_data,
  output logic [511:0] core_in,
  output logic         core_sel,
  output logic [3:0]   core_rc_idx,
  input  logic [511:0] core_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic         busy
);

  localparam int RW = $clog2(ROUNDS + 1);
  localparam int LW = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;
  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);
  localparam logic [LW-1:0] LAT_LAST   = LW'(CORE_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, CAPT, DONE} state_t;

  state_t        state_reg;
  logic [511:0]  block_reg;
  logic [RW-1:0] round_reg;
  logic [LW-1:0] lat_reg;
  logic [511:0]  core_in_reg;
  logic          core_sel_reg;
  logic [3:0]    rc_idx_reg;
  logic          in_ready_reg;
  logic          busy_reg;
  logic          out_valid_reg;
  logic [511:0]  out_data_reg;

  logic [RW-1:0] round_next;
  logic [511:0]  ff_mask;
  logic          last_cycle;

  assign round_next = round_reg + RW'(1);
  assign ff_mask    = (FEED_FORWARD != 0) ? block_reg : '0;
  // Final cycle of the last round: the core output is valid on the next cycle.
  assign last_cycle = (round_reg == ROUND_LAST) && (lat_reg == LAT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      block_reg     <= '0;
      round_reg     <= '0;
      lat_reg       <= '0;
      core_in_reg   <= '0;
      core_sel_reg  <= 1'b0;
      rc_idx_reg    <= '0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg    <= LOAD;
            block_reg    <= in_data;
            core_in_reg  <= in_data;
            core_sel_reg <= 1'b0;
            rc_idx_reg   <= '0;
            round_reg    <= '0;
            lat_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        LOAD, ITER: begin
          core_in_reg <= '0;
          if (last_cycle) begin
            state_reg    <= CAPT;
            core_sel_reg <= 1'b0;
            rc_idx_reg   <= '0;
            round_reg    <= '0;
            lat_reg      <= '0;
          end else begin
            state_reg    <= ITER;
            core_sel_reg <= 1'b1;
            if (lat_reg == LAT_LAST) begin
              lat_reg    <= '0;
              round_reg  <= round_next;
              rc_idx_reg <= 4'(round_next);
            end else begin
              lat_reg    <= lat_reg + LW'(1);
              rc_idx_reg <= 4'(round_reg);
            end
          end
        end
        CAPT: begin
          state_reg     <= DONE;
          out_data_reg  <= core_result ^ ff_mask;
          out_valid_reg <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          core_sel_reg  <= 1'b0;
          rc_idx_reg    <= '0;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign core_in     = core_in_reg;
  assign core_sel    = core_sel_reg;
  assign core_rc_idx = rc_idx_reg;
  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_haraka_s_ctrl.sv
// Bench for haraka_s_ctrl: cycle-exact checks on the default configuration against a
// toy core model, plus back-to-back sweeps over several ROUNDS/CORE_LATENCY/FEED_FORWARD sets.
module tb_haraka_s_ctrl;

  localparam int R = 5;
  localparam int L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Toy round function: rotate left by one and XOR a round-dependent word.
  function automatic logic [511:0] step(input logic [511:0] a, input int k);
    logic [31:0] w;
    w = 32'h9E3779B9 ^ (32'(k) * 32'h01000193);
    return {a[510:0], a[511]} ^ {16{w}};
  endfunction

  function automatic logic [511:0] model(input logic [511:0] blk, input int r, input int l, input int ff);
    logic [511:0] acc;
    acc = blk;
    for (int c = 1; c < r * l; c++) acc = step(acc, c / l);
    return (ff != 0) ? (acc ^ blk) : acc;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_w(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Main DUT (default parameters) with its toy core
  logic         rst, in_valid, in_ready, core_sel, out_valid, out_ready, busy;
  logic [511:0] in_data, core_in, core_result, out_data;
  logic [3:0]   core_rc_idx;
  logic [511:0] core_acc;

  haraka_s_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_in(core_in), .core_sel(core_sel), .core_rc_idx(core_rc_idx),
    .core_result(core_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always @(posedge clk) core_acc <= core_sel ? step(core_acc, int'(core_rc_idx)) : core_in;
  assign core_result = core_acc;

  task automatic run_block(input logic [511:0] data, input int delay, input bit intrude);
    logic [511:0] exp;
    exp = model(data, R, L, 1);
    in_valid = 1'b1;
    in_data  = data;
    chk_int("in_ready idle", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    in_data  = ~data;
    chk_int("load core_sel", int'(core_sel), 0);
    chk_w("load core_in", core_in, data);
    chk_int("load rc_idx", int'(core_rc_idx), 0);
    chk_int("load busy", int'(busy), 1);
    for (int c = 1; c < R * L; c++) begin
      in_valid = intrude;
      in_data  = data ^ {16{32'hDEADBEEF}};
      tick();
      chk_int("iter core_sel", int'(core_sel), 1);
      chk_int("iter rc_idx", int'(core_rc_idx), c / L);
      chk_w("iter core_in", core_in, '0);
      chk_int("iter in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    tick();
    chk_int("capt core_sel", int'(core_sel), 0);
    chk_int("capt rc_idx", int'(core_rc_idx), 0);
    chk_int("capt out_valid", int'(out_valid), 0);
    tick();
    chk_int("done out_valid", int'(out_valid), 1);
    chk_w("done out_data", out_data, exp);
    chk_int("done in_ready", int'(in_ready), 0);
    out_ready = (delay == 0);
    for (int d = 1; d <= delay; d++) begin
      tick();
      chk_int("hold out_valid", int'(out_valid), 1);
      chk_w("hold out_data", out_data, exp);
      chk_int("hold in_ready", int'(in_ready), 0);
      if (d == delay) out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
    chk_int("after hs out_valid", int'(out_valid), 0);
    chk_int("after hs in_ready", int'(in_ready), 1);
    chk_int("after hs busy", int'(busy), 0);
    $display("block %0h.. delay=%0d intrude=%0d done @cyc %0d", data[511:480], delay, intrude, cyc);
  endtask

  typedef struct {
    logic [511:0] data;
    int           delay;
    bit           intrude;
  } vec_t;

  vec_t vecs[4];

  // Back-to-back sweeps over other parameter sets
  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    localparam int SR = (gi == 1) ? 5 : 1;
    localparam int SL = (gi == 0) ? 1 : 3;
    localparam int SF = (gi == 1) ? 1 : 0;

    logic         s_rst, s_in_valid, s_in_ready, s_core_sel, s_out_valid, s_out_ready, s_busy;
    logic [511:0] s_in_data, s_core_in, s_core_result, s_out_data, s_acc;
    logic [3:0]   s_rc_idx;
    bit           done = 1'b0;

    haraka_s_ctrl #(.ROUNDS(SR), .CORE_LATENCY(SL), .FEED_FORWARD(SF)) dut_s (
      .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .core_in(s_core_in), .core_sel(s_core_sel), .core_rc_idx(s_rc_idx),
      .core_result(s_core_result), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_data(s_out_data), .busy(s_busy)
    );

    always @(posedge clk) s_acc <= s_core_sel ? step(s_acc, int'(s_rc_idx)) : s_core_in;
    assign s_core_result = s_acc;

    initial begin
      logic [511:0] blk_q[$];
      int           acc_q[$];
      logic [511:0] blk;
      int           a_cyc, sent, got, guard;
      s_rst = 1'b1; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
      repeat (3) tick();
      s_rst = 1'b0;
      sent = 0; got = 0; guard = 0;
      while (got < 50 && guard < 3000) begin
        if (s_out_valid) begin
          if (blk_q.size() == 0) begin
            chk_int("sweep unexpected out_valid", 1, 0);
          end else begin
            blk   = blk_q.pop_front();
            a_cyc = acc_q.pop_front();
            chk_w("sweep out_data", s_out_data, model(blk, SR, SL, SF));
            chk_int("sweep latency", cyc - a_cyc, SR * SL + 2);
            $display("sweep R=%0d L=%0d FF=%0d block %0d latency %0d", SR, SL, SF, got, cyc - a_cyc);
          end
          got++;
        end
        chk_int("sweep rc_idx range", int'(s_rc_idx < 4'(SR)), 1);
        s_in_valid = (sent < 50);
        if (sent < 50) s_in_data = rand512();
        if (s_in_valid && s_in_ready) begin
          blk_q.push_back(s_in_data);
          acc_q.push_back(cyc);
          sent++;
        end
        tick();
        guard++;
      end
      chk_int("sweep blocks received", got, 50);
      done = 1'b1;
    end
  end

  initial begin
    bit seen;
    int w;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = rand512();
      out_ready = 1'($urandom_range(0, 1));
      tick();
      chk_int("rst out_valid", int'(out_valid), 0);
      chk_w("rst out_data", out_data, '0);
      chk_int("rst core_sel", int'(core_sel), 0);
      chk_int("rst rc_idx", int'(core_rc_idx), 0);
      chk_int("rst busy", int'(busy), 0);
      chk_w("rst core_in", core_in, '0);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk_int("post-rst in_ready", int'(in_ready), 1);
    chk_int("post-rst busy", int'(busy), 0);

    vecs[0] = '{data: '0, delay: 0, intrude: 1'b0};
    vecs[1] = '{data: '0, delay: 20, intrude: 1'b0};
    vecs[2] = '{data: {64{8'hA5}}, delay: 1, intrude: 1'b1};
    vecs[3] = '{data: {16{32'h0123_4567}}, delay: 3, intrude: 1'b1};
    for (int v = 0; v < 4; v++) run_block(vecs[v].data, vecs[v].delay, vecs[v].intrude);

    // Abort mid-iteration at rc_idx=3
    in_valid = 1'b1;
    in_data  = {16{32'hCAFE_F00D}};
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk_int("abort rc_idx", int'(core_rc_idx), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_int("abort busy", int'(busy), 0);
    chk_int("abort in_ready", int'(in_ready), 1);
    chk_int("abort core_sel", int'(core_sel), 0);
    chk_int("abort rc_idx cleared", int'(core_rc_idx), 0);
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk_int("abort no out_valid", int'(seen), 0);
    run_block({16{32'h1357_9BDF}}, 2, 1'b0);

    // out_ready while idle has no effect
    out_ready = 1'b1;
    tick();
    chk_int("idle out_ready out_valid", int'(out_valid), 0);
    chk_int("idle out_ready in_ready", int'(in_ready), 1);
    out_ready = 1'b0;

    w = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && w < 5000) begin
      tick();
      w++;
    end
    chk_int("sweeps finished", int'(g_sw[0].done && g_sw[1].done && g_sw[2].done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
